// File: rtl/unbus16.sv
// unbus16: registered 16-bit word-to-bit unpacker with MSB-first serial shifter.
// Define UNBUS16_PARITY_EN to append an even-parity bit to every frame.
module unbus16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] D,
    output logic        ready,
    output logic        busy,
    output logic        SO,
    output logic        SO_valid,
    output logic        done,
    output logic        Q15,
    output logic        Q14,
    output logic        Q13,
    output logic        Q12,
    output logic        Q11,
    output logic        Q10,
    output logic        Q9,
    output logic        Q8,
    output logic        Q7,
    output logic        Q6,
    output logic        Q5,
    output logic        Q4,
    output logic        Q3,
    output logic        Q2,
    output logic        Q1,
    output logic        Q0
);

    typedef enum logic [1:0] {
`ifdef UNBUS16_PARITY_EN
        PARITY = 2'd2,
`endif
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } state_t;

`ifdef UNBUS16_PARITY_EN
    localparam logic DONE_ON_DATA = 1'b0;
`else
    localparam logic DONE_ON_DATA = 1'b1;
`endif

    state_t      state_q;
    logic [15:0] hold_q;
    logic [15:0] shift_q;
    logic [3:0]  cnt_q;
    logic        so_q;
    logic        so_valid_q;
    logic        done_q;
    logic        busy_q;

    // Outputs are produced one edge ahead so every port comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every read of a _q below sees the pre-edge value.
            case (state_q)
                IDLE: begin
                    if (load) begin
                        hold_q     <= D;
                        shift_q    <= D;
                        cnt_q      <= '0;
                        state_q    <= SHIFT;
                        so_q       <= D[15];
                        so_valid_q <= 1'b1;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    shift_q <= {shift_q[14:0], 1'b0};
                    if (cnt_q == 4'd15) begin
`ifdef UNBUS16_PARITY_EN
                        state_q    <= PARITY;
                        so_q       <= ^hold_q;
                        done_q     <= 1'b1;
`else
                        state_q    <= IDLE;
                        so_q       <= 1'b0;
                        so_valid_q <= 1'b0;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b0;
`endif
                    end else begin
                        cnt_q  <= cnt_q + 4'd1;
                        so_q   <= shift_q[14];
                        done_q <= DONE_ON_DATA && (cnt_q == 4'd14);
                    end
                end
`ifdef UNBUS16_PARITY_EN
                PARITY: begin
                    state_q    <= IDLE;
                    so_q       <= 1'b0;
                    so_valid_q <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                end
`endif
                default: begin
                    state_q    <= IDLE;
                    so_q       <= 1'b0;
                    so_valid_q <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign ready    = ~busy_q;
    assign busy     = busy_q;
    assign SO       = so_q;
    assign SO_valid = so_valid_q;
    assign done     = done_q;

    assign {Q15, Q14, Q13, Q12, Q11, Q10, Q9, Q8,
            Q7,  Q6,  Q5,  Q4,  Q3,  Q2,  Q1, Q0} = hold_q;

endmodule

// File: tb/tb_unbus16.sv
// Bench for unbus16: table-driven frames, hand-written corner sequences and
// random words compared against an expected MSB-first bit stream model.
module tb_unbus16;

`ifdef UNBUS16_PARITY_EN
    localparam int FRAME = 17;
`else
    localparam int FRAME = 16;
`endif

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] D;
    logic        ready, busy, SO, SO_valid, done;
    logic        Q15, Q14, Q13, Q12, Q11, Q10, Q9, Q8;
    logic        Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0;
    logic [15:0] q;

    assign q = {Q15, Q14, Q13, Q12, Q11, Q10, Q9, Q8, Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0};

    int n_vec = 0;
    int n_err = 0;

    unbus16 dut (
        .clk(clk), .rst(rst), .load(load), .D(D),
        .ready(ready), .busy(busy), .SO(SO), .SO_valid(SO_valid), .done(done),
        .Q15(Q15), .Q14(Q14), .Q13(Q13), .Q12(Q12), .Q11(Q11), .Q10(Q10), .Q9(Q9), .Q8(Q8),
        .Q7(Q7), .Q6(Q6), .Q5(Q5), .Q4(Q4), .Q3(Q3), .Q2(Q2), .Q1(Q1), .Q0(Q0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [15:0] exp_q);
        check({tag, ".ready"},    16'(ready),    16'd1);
        check({tag, ".busy"},     16'(busy),     16'd0);
        check({tag, ".SO"},       16'(SO),       16'd0);
        check({tag, ".SO_valid"}, 16'(SO_valid), 16'd0);
        check({tag, ".done"},     16'(done),     16'd0);
        check({tag, ".Q"},        q,             exp_q);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".ready_timeout"}, 16'(ready), 16'd1);
    endtask

    // Called at a falling edge with ready=1; returns at the falling edge of the
    // idle cycle that follows the frame.
    task automatic frame(input logic [15:0] w, input logic exp_par, input logic keep_load,
                         input logic [15:0] d_busy, input logic noise, input string tag);
        logic exp_so;
        wait_ready(tag);
        load = 1'b1;
        D    = w;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (noise) begin
                load = 1'($urandom);
                D    = 16'($urandom);
            end else if (keep_load) begin
                D = d_busy;
            end else begin
                load = 1'b0;
            end
            exp_so = (i < 16) ? w[15 - i] : exp_par;
            check($sformatf("%s.SO[%0d]", tag, i),       16'(SO),       16'(exp_so));
            check($sformatf("%s.SO_valid[%0d]", tag, i), 16'(SO_valid), 16'd1);
            check($sformatf("%s.done[%0d]", tag, i),     16'(done),     16'(i == FRAME - 1));
            check($sformatf("%s.busy[%0d]", tag, i),     16'(busy),     16'd1);
            check($sformatf("%s.ready[%0d]", tag, i),    16'(ready),    16'd0);
            check($sformatf("%s.Q[%0d]", tag, i),        q,             w);
        end
        @(negedge clk);
        check_idle({tag, ".end"}, w);
        if (!keep_load) load = 1'b0;
    endtask

    typedef struct packed {
        logic [15:0] d;
        logic        par;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [15:0] w;
        vecs[0] = '{d: 16'hA5C3, par: 1'b0};
        vecs[1] = '{d: 16'h0000, par: 1'b0};
        vecs[2] = '{d: 16'hFFFF, par: 1'b0};
        vecs[3] = '{d: 16'h0001, par: 1'b1};
        vecs[4] = '{d: 16'h0003, par: 1'b0};
        vecs[5] = '{d: 16'h1234, par: 1'b1};

        // Reset state, with load asserted during reset.
        rst  = 1'b1;
        load = 1'b1;
        D    = 16'hFFFF;
        repeat (3) @(negedge clk);
        check_idle("reset", 16'h0000);
        rst  = 1'b0;
        load = 1'b0;
        @(negedge clk);
        check_idle("post_reset", 16'h0000);

        // Table frames, applied back to back (0000 then FFFF has one idle cycle).
        for (int v = 0; v < 6; v++)
            frame(vecs[v].d, vecs[v].par, 1'b0, 16'h0000, 1'b0, $sformatf("vec%0d", v));

        // Persistence of Q after the 1234 frame.
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check($sformatf("persist.SO[%0d]", c),       16'(SO),       16'd0);
            check($sformatf("persist.SO_valid[%0d]", c), 16'(SO_valid), 16'd0);
        end
        check_idle("persist", 16'h1234);

        // load held high; D changes once shifting starts and must not be taken.
        frame(16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, "ignore_a");
        frame(16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, "ignore_b");

        // Reset mid-frame after 5 bits of A5C3.
        w    = 16'hA5C3;
        load = 1'b1;
        D    = w;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            load = 1'b0;
            check($sformatf("abort.SO[%0d]", i), 16'(SO), 16'(w[15 - i]));
        end
        #2 rst = 1'b1;
        #1 check_idle("abort_async", 16'h0000);
        @(negedge clk);
        check_idle("abort_held", 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check_idle("abort_release", 16'h0000);

        // Random words with random gaps and random load/D noise while busy.
        for (int r = 0; r < 20; r++) begin
            w = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            frame(w, 1'($countones(w) & 1), 1'b0, 16'h0000, 1'b1, $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
